// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem handshake, 2-entry decode FIFO
// One request outstanding at most; a redirect while waiting marks the in-flight response for drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q [2];
  logic        grant;
  logic        push;
  logic        pop;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    imem_req = (state_q == S_REQ) && (cnt_q != 2'd2) && !redirect;
    grant    = imem_req && imem_gnt;
    id_valid = (cnt_q != 2'd0) && !redirect;
    pop      = id_valid && id_ready;
    push     = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;

    case (state_q)
      S_REQ: begin
        if (grant) begin
          req_pc_d = pc_q;
          pc_d     = next_pc;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Flush leaves the pointers aligned so the FIFO reads as empty.
    if (redirect) begin
      pc_d     = next_pc;
      cnt_d    = 2'd0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign pc_out    = pc_q;
  assign imem_addr = pc_q;
  assign id_instr  = fifo_instr_q[rd_ptr_q];
  assign id_pc     = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural memory and PC-stream model
// The PC adder and instruction memory are modelled here; rdata is always addr ^ 32'hFFFF.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] next_pc;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  fetch_stage #(.RESET_PC(32'h40)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .next_pc(next_pc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // PC adder: +1 sequential, or the redirect target.
  always_comb next_pc = redirect ? target : pc_out + 32'd1;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  int          gnt_lat = 0;
  int          resp_lat = 1;
  bit          rnd_mem = 1'b0;
  int          gnt_wait = 0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  int          pend_c = 0;
  logic        last_req = 1'b0;
  logic        last_gnt = 1'b0;
  logic [31:0] last_addr = 32'h0;

  logic [31:0] dq_pc[$];
  logic [31:0] dq_instr[$];
  int          dq_cyc[$];
  logic [31:0] gq_addr[$];
  int          gq_cyc[$];

  task automatic cycle();
    logic s_req, s_gnt, s_rv, s_pop;
    logic [31:0] s_addr, s_pc, s_instr;
    #1;
    imem_gnt    = imem_req && (gnt_wait >= gnt_lat);
    if (rnd_mem && !imem_req) imem_gnt = 1'($urandom_range(0, 1));
    imem_rvalid = pend_v && (pend_c <= 1);
    imem_rdata  = imem_rvalid ? (pend_a ^ 32'hFFFF) : $urandom;
    #1;
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
    s_pop = id_valid && id_ready; s_pc = id_pc; s_instr = id_instr;
    @(posedge clk);
    if (rst_n && s_pop) begin
      dq_pc.push_back(s_pc); dq_instr.push_back(s_instr); dq_cyc.push_back(cyc);
    end
    if (s_rv) pend_v = 1'b0;
    else if (pend_v) pend_c--;
    if (rst_n && s_req && s_gnt) begin
      gq_addr.push_back(s_addr); gq_cyc.push_back(cyc);
      pend_v = 1'b1; pend_a = s_addr; pend_c = resp_lat; gnt_wait = 0;
      if (rnd_mem) begin
        gnt_lat  = $urandom_range(0, 3);
        resp_lat = $urandom_range(1, 3);
      end
    end else if (s_req) gnt_wait++;
    else gnt_wait = 0;
    last_req = s_req; last_gnt = s_gnt; last_addr = s_addr;
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    dq_pc.delete(); dq_instr.delete(); dq_cyc.delete();
    gq_addr.delete(); gq_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0;
    cycle();
    rst_n = 1'b1; pend_v = 1'b0; gnt_wait = 0;
    clear_logs();
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (gq_addr.size() < n && k < 100) begin cycle(); k++; end
    nvec++;
    if (gq_addr.size() < n) begin
      nerr++; $display("FAIL grant_timeout: got %0d grants, required %0d", gq_addr.size(), n);
    end
  endtask

  task automatic wait_deliv(input int n);
    int k = 0;
    while (dq_pc.size() < n && k < 100) begin cycle(); k++; end
    nvec++;
    if (dq_pc.size() < n) begin
      nerr++; $display("FAIL deliver_timeout: got %0d entries, required %0d", dq_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    gnt_lat = 0; resp_lat = 1; id_ready = 1'b1;
    do_reset();
    nvec++; if (pc_out !== 32'h40) begin nerr++; $display("FAIL reset_pc: got %h, required 00000040", pc_out); end
    nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL reset_id_valid: got %b, required 0", id_valid); end
    nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL reset_req: got %b, required 1", imem_req); end
    wait_deliv(3);
    if (dq_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        e = 32'h40 + 32'(i);
        nvec++;
        if (dq_pc[i] !== e || dq_instr[i] !== (e ^ 32'hFFFF)) begin
          nerr++; $display("FAIL reset_stream[%0d]: got (%h,%h), required (%h,%h)", i, dq_pc[i], dq_instr[i], e, e ^ 32'hFFFF);
        end
      end
      nvec++;
      if (dq_cyc[0] - gq_cyc[0] !== 2) begin
        nerr++; $display("FAIL first_valid_latency: got %0d, required 2", dq_cyc[0] - gq_cyc[0]);
      end
      nvec++;
      if (gq_cyc[1] - gq_cyc[0] !== 2) begin
        nerr++; $display("FAIL issue_interval: got %0d, required 2", gq_cyc[1] - gq_cyc[0]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] e;
    gnt_lat = 0; resp_lat = 1; id_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL bp_req: got %b, required 0", imem_req); end
    nvec++; if (pc_out !== 32'h42) begin nerr++; $display("FAIL bp_pc: got %h, required 00000042", pc_out); end
    nvec++; if (gq_addr.size() !== 2) begin nerr++; $display("FAIL bp_fetches: got %0d, required 2", gq_addr.size()); end
    nvec++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin nerr++; $display("FAIL bp_head: got %b/%h, required 1/00000040", id_valid, id_pc); end
    id_ready = 1'b1;
    wait_deliv(3);
    if (dq_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        e = 32'h40 + 32'(i);
        nvec++;
        if (dq_pc[i] !== e || dq_instr[i] !== (e ^ 32'hFFFF)) begin
          nerr++; $display("FAIL bp_stream[%0d]: got (%h,%h), required (%h,%h)", i, dq_pc[i], dq_instr[i], e, e ^ 32'hFFFF);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    int gc, nd;
    gnt_lat = 0; resp_lat = 1; id_ready = 1'b1;
    do_reset();
    wait_grants(3);
    resp_lat = 3;
    wait_grants(4);
    if (gq_addr.size() < 4) return;
    gc = gq_cyc[3];
    nvec++; if (gq_addr[3] !== 32'h43) begin nerr++; $display("FAIL rw_grant_addr: got %h, required 00000043", gq_addr[3]); end
    redirect = 1'b1; target = 32'h100; resp_lat = 1;
    #1;
    nvec++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rw_req_in_redirect: got %b, required 0", imem_req); end
    nd = dq_pc.size();
    cycle();
    redirect = 1'b0;
    nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rw_flush: got id_valid %b, required 0", id_valid); end
    wait_grants(5);
    if (gq_addr.size() >= 5) begin
      nvec++; if (gq_addr[4] !== 32'h100) begin nerr++; $display("FAIL rw_target_addr: got %h, required 00000100", gq_addr[4]); end
      nvec++; if (gq_cyc[4] - gc !== 4) begin nerr++; $display("FAIL rw_target_time: got %0d, required 4", gq_cyc[4] - gc); end
    end
    wait_deliv(nd + 1);
    if (dq_pc.size() > nd) begin
      nvec++;
      if (dq_pc[nd] !== 32'h100 || dq_instr[nd] !== 32'h0000FEFF) begin
        nerr++; $display("FAIL rw_next_id: got (%h,%h), required (00000100,0000feff)", dq_pc[nd], dq_instr[nd]);
      end
    end
  endtask

  task automatic test_redirect_on_response();
    gnt_lat = 0; resp_lat = 1; id_ready = 1'b0;
    do_reset();
    wait_grants(2);
    redirect = 1'b1; target = 32'h200;
    #1;
    nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rr_id_valid: got %b, required 0", id_valid); end
    cycle();
    redirect = 1'b0;
    #1;
    nvec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      nerr++; $display("FAIL rr_next_req: got %b/%h, required 1/00000200", imem_req, imem_addr);
    end
    nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rr_discard: got id_valid %b, required 0", id_valid); end
    id_ready = 1'b1;
    wait_deliv(1);
    if (dq_pc.size() >= 1) begin
      nvec++;
      if (dq_pc[0] !== 32'h200 || dq_instr[0] !== 32'h0000FDFF) begin
        nerr++; $display("FAIL rr_target_id: got (%h,%h), required (00000200,0000fdff)", dq_pc[0], dq_instr[0]);
      end
    end
  endtask

  task automatic test_slow_grant();
    int s0, n40;
    gnt_lat = 3; resp_lat = 1; id_ready = 1'b1;
    do_reset();
    s0 = cyc;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
        nerr++; $display("FAIL sg_hold[%0d]: got %b/%h, required 1/00000040", i, imem_req, imem_addr);
      end
      cycle();
    end
    nvec++;
    if (gq_addr.size() !== 1 || gq_cyc[0] - s0 !== 3) begin
      nerr++; $display("FAIL sg_grant: got %0d grants, required 1 at offset 3", gq_addr.size());
    end
    repeat (12) cycle();
    n40 = 0;
    foreach (gq_addr[i]) if (gq_addr[i] == 32'h40) n40++;
    nvec++; if (n40 !== 1) begin nerr++; $display("FAIL sg_single_fetch: got %0d, required 1", n40); end
    n40 = 0;
    foreach (dq_pc[i]) if (dq_pc[i] == 32'h40) n40++;
    nvec++; if (n40 !== 1) begin nerr++; $display("FAIL sg_single_deliver: got %0d, required 1", n40); end
    gnt_lat = 0;
  endtask

  task automatic test_reset_mid();
    gnt_lat = 0; resp_lat = 1; id_ready = 1'b0;
    do_reset();
    wait_grants(1);
    resp_lat = 2;
    wait_grants(2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    clear_logs();
    nvec++; if (pc_out !== 32'h40) begin nerr++; $display("FAIL rm_pc: got %h, required 00000040", pc_out); end
    nvec++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL rm_id_valid: got %b, required 0", id_valid); end
    nvec++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL rm_req: got %b, required 1", imem_req); end
    id_ready = 1'b1;
    wait_deliv(2);
    if (dq_pc.size() >= 2) begin
      nvec++;
      if (dq_pc[0] !== 32'h40 || dq_instr[0] !== 32'h0000FFBF) begin
        nerr++; $display("FAIL rm_first: got (%h,%h), required (00000040,0000ffbf)", dq_pc[0], dq_instr[0]);
      end
      nvec++;
      if (dq_pc[1] !== 32'h41 || dq_instr[1] !== 32'h0000FFBE) begin
        nerr++; $display("FAIL rm_second: got (%h,%h), required (00000041,0000ffbe)", dq_pc[1], dq_instr[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int total;
    bit rd;
    rnd_mem = 1'b1; gnt_lat = 0; resp_lat = 1;
    do_reset();
    exp_pc = 32'h40; total = 0;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 15) == 0);
      redirect = rd;
      target   = $urandom & 32'h0000_FFF0;
      id_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (last_req && !last_gnt && !rd) begin
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== last_addr) begin
          nerr++; $display("FAIL rnd_req_stable: got %b/%h, required 1/%h", imem_req, imem_addr, last_addr);
        end
      end
      cycle();
      while (dq_pc.size() > 0) begin
        nvec++;
        if (dq_pc[0] !== exp_pc || dq_instr[0] !== (exp_pc ^ 32'hFFFF)) begin
          nerr++; $display("FAIL rnd_stream: got (%h,%h), required (%h,%h)", dq_pc[0], dq_instr[0], exp_pc, exp_pc ^ 32'hFFFF);
        end
        void'(dq_pc.pop_front()); void'(dq_instr.pop_front()); void'(dq_cyc.pop_front());
        exp_pc = exp_pc + 32'd1;
        total++;
      end
      if (rd) exp_pc = target;
      redirect = 1'b0;
    end
    nvec++; if (total < 100) begin nerr++; $display("FAIL rnd_progress: got %0d deliveries, required >= 100", total); end
    rnd_mem = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_on_response();
    test_slow_grant();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of the PC adder. It owns the architectural PC register, presents it on `pc_out` to the PC adder, and loads the adder's `next_pc` result. Each PC is issued to instruction memory over a request/grant/response handshake, and returned instructions are buffered in a 2-entry FIFO for the decode stage. PCs are word addresses: sequential advance is +1, computed by the PC adder, not here.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `pc_out`  out  32  current PC register; feeds the PC adder's address input.
- `next_pc`  in  32  PC adder result: sequential PC, or jump/branch target when `redirect`=1.
- `redirect`  in  1  `next_pc` is a non-sequential target; flush the stage.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address; equals `pc_out`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid; responses return in order.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  head FIFO entry is valid for decode.
- `id_instr`  out  32  instruction at the FIFO head.
- `id_pc`  out  32  PC of `id_instr`.
- `id_ready`  in  1  decode accepts the head entry when `id_valid`&&`id_ready`.

## Operation
- **State machine:** `S_REQ` (may issue) and `S_WAIT` (one request outstanding). At most one request is outstanding.
- **Reset** (rst_n=0 at an edge):
  - state←`S_REQ`; `pc_out`←`RESET_PC`; FIFO count←0; drop flag←0.
  - Entries are not cleared; `id_valid` is 0 while count=0.
- **Request:** `imem_req` = (state==`S_REQ`) && (count<2) && !`redirect`.
  - `imem_addr` = `pc_out`.
  - `imem_req` stays asserted and the address stays stable until `imem_gnt`, unless a redirect occurs.
- **Grant** (`imem_req`&&`imem_gnt`):
  - req_pc←`pc_out`; `pc_out`←`next_pc`; state←`S_WAIT`.
- **S_WAIT, response** (`imem_rvalid`):
  - If drop=0, push {req_pc, `imem_rdata`} into the FIFO; if drop=1, discard the response and clear drop.
  - state←`S_REQ`.
- **Redirect** (any state):
  - `pc_out`←`next_pc`; FIFO count←0. A pop on the same edge is void.
  - If in `S_WAIT` with no `imem_rvalid` this cycle: drop←1; stay in `S_WAIT`.
  - If in `S_WAIT` with `imem_rvalid` this cycle: the response is discarded; state←`S_REQ`.
  - `imem_req` is forced to 0 during the redirect cycle, so no grant is possible.
- **FIFO:** 2 entries with circular read/write pointers that wrap at 2.
  - Push and pop on the same edge is allowed.
  - A push is never attempted when count=2: issue is gated by count<2, and at most one response can be in flight.
- **Decode output:** `id_valid` = (count!=0) && !`redirect`; `id_instr`/`id_pc` come from the head entry.
- **Protocol violations:** `imem_rvalid` in `S_REQ` is ignored, with no state change. `imem_gnt` without `imem_req` is ignored.

## Timing
- `pc_out` is registered; the PC adder path `pc_out`→`next_pc` is combinational within one cycle.
- Minimum latency, with zero-wait grant and 1-cycle response:
  - Grant at edge N, `imem_rvalid` in cycle N+1.
  - Push at edge N+1; `id_valid`=1 in cycle N+2.
- Throughput: one fetch per 2 cycles at best, because `S_REQ` and `S_WAIT` alternate.
- Stall: with `id_ready`=0 and count=2, `imem_req`=0 until a pop. Issue resumes the cycle after the pop edge.
- Redirect takes effect at the next edge. The first request to the target is issued the cycle after the redirect, or after the dropped response returns.

## Test plan
- **Reset:** RESET_PC=32'h40, `next_pc`=`pc_out`+1, memory grants immediately and responds next cycle with rdata=addr^32'hFFFF. Required:
  - Decode receives {pc,instr}=(0x40,0xFFBF), (0x41,0xFFBE), (0x42,0xFFBD).
  - `id_valid` first rises 2 cycles after the first grant.
- **Back-pressure:** `id_ready`=0 for 10 cycles. Required:
  - Count saturates at 2; `imem_req` drops to 0; `pc_out` holds at 0x42.
  - When `id_ready` returns to 1, entries 0x40 and 0x41 are delivered in order with none lost.
- **Redirect while waiting:** redirect with `next_pc`=0x100 in the `S_WAIT` cycle after PC 0x43 is granted; response arrives 2 cycles later. Required:
  - 0x43 is dropped and the FIFO is flushed.
  - The next request address is 0x100; the next `id_pc` is 0x100.
- **Redirect on response:** redirect and `imem_rvalid` in the same cycle. Required:
  - The response is discarded; drop stays 0.
  - `id_valid`=0 in the redirect cycle; the target is fetched next.
- **Slow grant:** `imem_gnt` delayed 3 cycles. Required:
  - `imem_req` and `imem_addr`=0x40 are held stable for 4 cycles.
  - Exactly one fetch of 0x40 occurs.
- **Reset mid-operation:** `rst_n`=0 for one edge while in `S_WAIT` with count=1. Required:
  - Next cycle: `pc_out`=RESET_PC, `id_valid`=0, `imem_req`=1.
  - The stale response is ignored, because it arrives in `S_REQ`.
